// File: rtl/if_fetch_buffer.sv
// Instruction-fetch buffer between the PC stage and decode: issues fetch requests,
// collects in-order responses and hands {addr, inst} pairs to decode; flush discards all.
module if_fetch_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_i,
    input  logic          pc_valid_i,
    output logic          pc_ready_o,
    input  logic          flush_i,
    output logic          imem_req_valid_o,
    output logic [AW-1:0] imem_req_addr_o,
    input  logic          imem_req_ready_i,
    input  logic          imem_rsp_valid_i,
    input  logic [DW-1:0] imem_rsp_data_i,
    output logic          inst_valid_o,
    output logic [DW-1:0] inst_o,
    output logic [AW-1:0] inst_addr_o,
    input  logic          inst_ready_i,
    output logic          err_o
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;
    localparam logic [PW:0] DEPTH_W = DEPTH[PW:0];

    logic [PW-1:0] alloc_ptr, fill_ptr, rd_ptr, drop_cnt;
    logic [PW-1:0] count, outstanding;
    logic [PW:0]   occupancy;
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic          err_q;
    logic          credit, accept, pop;
    logic          rsp_drop, rsp_fill, rsp_spur;
    logic [IW-1:0] alloc_idx, fill_idx, rd_idx;

    always_comb begin
        count       = alloc_ptr - rd_ptr;
        outstanding = alloc_ptr - fill_ptr;
        occupancy   = {1'b0, count} + {1'b0, drop_cnt};
        credit      = occupancy < DEPTH_W;
        alloc_idx   = alloc_ptr[IW-1:0];
        fill_idx    = fill_ptr[IW-1:0];
        rd_idx      = rd_ptr[IW-1:0];

        imem_req_valid_o = pc_valid_i & credit & ~flush_i;
        imem_req_addr_o  = pc_i;
        // rst term holds the PC stage while reset is asserted
        pc_ready_o       = imem_req_valid_o & imem_req_ready_i & ~rst;
        accept           = pc_ready_o;

        inst_valid_o = filled_q[rd_idx] & (count != '0) & ~flush_i;
        inst_o       = data_q[rd_idx];
        inst_addr_o  = addr_q[rd_idx];
        pop          = inst_valid_o & inst_ready_i;

        rsp_drop = imem_rsp_valid_i & (drop_cnt != '0);
        rsp_fill = imem_rsp_valid_i & (drop_cnt == '0) & (outstanding != '0);
        rsp_spur = imem_rsp_valid_i & (drop_cnt == '0) & (outstanding == '0);

        err_o = err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            drop_cnt  <= '0;
            filled_q  <= '0;
            err_q     <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (rsp_spur)
                err_q <= 1'b1;
            if (flush_i) begin
                // Everything issued so far becomes owed-and-discarded; a response
                // arriving this same cycle already settles one of those.
                drop_cnt <= drop_cnt + outstanding - PW'(rsp_drop | rsp_fill);
                fill_ptr <= alloc_ptr;
                rd_ptr   <= alloc_ptr;
                filled_q <= '0;
            end else begin
                // Accept, fill and pop always touch distinct entries, so the
                // individual filled-bit writes never collide.
                if (accept) begin
                    addr_q[alloc_idx]   <= pc_i;
                    filled_q[alloc_idx] <= 1'b0;
                    alloc_ptr           <= alloc_ptr + PW'(1);
                end
                if (rsp_drop) begin
                    drop_cnt <= drop_cnt - PW'(1);
                end else if (rsp_fill) begin
                    data_q[fill_idx]   <= imem_rsp_data_i;
                    filled_q[fill_idx] <= 1'b1;
                    fill_ptr           <= fill_ptr + PW'(1);
                end
                if (pop) begin
                    filled_q[rd_idx] <= 1'b0;
                    rd_ptr           <= rd_ptr + PW'(1);
                end
            end
        end
    end
endmodule
